itof_pipe: RTL and testbench



---
 rtl/itof_pipe.sv | 125 ++++++++++++
 tb/tb_itof_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/itof_pipe.sv
// Pipelined signed 32-bit integer to IEEE-754 single converter with valid/ready backpressure.
// Define ITOF_ROUND_TRUNC_EN for round-toward-zero; default is round-to-nearest-even.
module itof_pipe #(
  parameter int unsigned LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int unsigned FRAC_W = 23;
  localparam int unsigned EXP_W  = 8;
`ifdef ITOF_ROUND_TRUNC_EN
  localparam int unsigned NORM_LSB = 8;
`else
  localparam int unsigned NORM_LSB = 0;
`endif
  // norm keeps only the bits below the implicit leading one that rounding needs
  localparam int unsigned NORM_W = 31 - NORM_LSB;

  if (LAT != 3) begin : g_lat_check
    $error("itof_pipe: LAT must be 3");
  end

  // All stages move together; a stalled output freezes the whole pipe.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Input capture
  logic        v0;
  logic [31:0] d0;

  // S1: sign / magnitude / zero
  logic        v1;
  logic        sign1;
  logic        zero1;
  logic [31:0] mag1;
  logic [31:0] mag_c;

  assign mag_c = d0[31] ? (32'd0 - d0) : d0;

  // S2: normalise
  logic              v2;
  logic              sign2;
  logic              zero2;
  logic [NORM_W-1:0] norm2;
  logic [EXP_W-1:0]  exp2;
  logic [4:0]        lz_c;
  logic [NORM_W-1:0] norm_c;
  logic [EXP_W-1:0]  exp_c;

  function automatic logic [4:0] lzc(input logic [31:0] x);
    lzc = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) lzc = 5'(31 - i);
    end
  endfunction

  assign lz_c   = lzc(mag1);
  assign norm_c = NORM_W'((mag1 << lz_c) >> NORM_LSB);
  assign exp_c  = 8'd158 - 8'(lz_c);

  // S3: round and pack
  logic [FRAC_W-1:0] frac_c;
  logic              inc_c;
  logic [FRAC_W:0]   sum_c;
  logic [EXP_W-1:0]  exponent_c;
  logic [31:0]       result_c;

  assign frac_c = norm2[NORM_W-1 -: FRAC_W];

`ifdef ITOF_ROUND_TRUNC_EN
  assign inc_c = 1'b0;
`else
  logic guard_c;
  logic sticky_c;
  assign guard_c  = norm2[7];
  assign sticky_c = |norm2[6:0];
  assign inc_c    = guard_c & (sticky_c | frac_c[0]);
`endif

  // A carry out of the fraction leaves frac = 0, which is exactly the low bits of the sum.
  assign sum_c      = {1'b0, frac_c} + (FRAC_W + 1)'(inc_c);
  assign exponent_c = exp2 + EXP_W'(sum_c[FRAC_W]);
  assign result_c   = zero2 ? 32'h0000_0000 : {sign2, exponent_c, sum_c[FRAC_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      d0        <= '0;
      v1        <= 1'b0;
      sign1     <= 1'b0;
      zero1     <= 1'b0;
      mag1      <= '0;
      v2        <= 1'b0;
      sign2     <= 1'b0;
      zero2     <= 1'b0;
      norm2     <= '0;
      exp2      <= '0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
    end else if (adv) begin
      v0        <= in_valid;
      d0        <= in_data;
      v1        <= v0;
      sign1     <= d0[31];
      zero1     <= (d0 == 32'd0);
      mag1      <= mag_c;
      v2        <= v1;
      sign2     <= sign1;
      zero2     <= zero1;
      norm2     <= norm_c;
      exp2      <= exp_c;
      out_valid <= v2;
      if (v2) out_data <= result_c;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: arithmetic reference model, scoreboard and directed phases.
// Define ITOF_ROUND_TRUNC_EN here as well when checking the truncating build.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  itof_pipe #(.LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

`ifdef ITOF_ROUND_TRUNC_EN
  localparam bit TRUNC = 1'b1;
  localparam logic [31:0] DIR_EXP [10] = '{
    32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h4B80_0000,
    32'h4B80_0001, 32'h4EFF_FFFF, 32'h4B7F_FFFF, 32'hC000_0000, 32'hCEFF_FFFF};
`else
  localparam bit TRUNC = 1'b0;
  localparam logic [31:0] DIR_EXP [10] = '{
    32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h4B80_0000,
    32'h4B80_0002, 32'h4F00_0000, 32'h4B7F_FFFF, 32'hC000_0000, 32'hCF00_0000};
`endif
  localparam logic [31:0] DIR_IN [10] = '{
    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0100_0001,
    32'h0100_0003, 32'h7FFF_FFFF, 32'h00FF_FFFF, 32'hFFFF_FFFE, 32'h8000_0001};
  localparam logic [31:0] BP_IN [5] = '{
    32'd5, 32'hFFFF_FED4, 32'h1234_5678, 32'h8000_0001, 32'd100};

  typedef struct {
    logic [31:0] val;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  bit   lat_chk = 1'b0;
  bit   low_seen = 1'b0;
  bit   rnd_on = 1'b0;
  bit   hold_prev = 1'b0;
  logic [31:0] data_prev = 32'h0;

  // Value-level conversion: find the top bit, shift the mantissa out, round on the remainder.
  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    longint m, mant, rem, half;
    int     e, sh;
    bit     s, rnd;
    if (x == 32'h0) return 32'h0;
    s = x[31];
    m = longint'($signed(x));
    if (m < 0) m = -m;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      mant = m << (23 - e);
    end else begin
      sh   = e - 23;
      mant = m >> sh;
      rem  = m - (mant << sh);
      half = longint'(1) << (sh - 1);
      rnd  = (rem > half) || ((rem == half) && mant[0]);
      if (rnd && !TRUNC) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = longint'(1) << 23;
        e++;
      end
    end
    return {s, 8'(e + 127), mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: inputs are sampled mid-cycle, so a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, data_prev);
      end
      if (out_valid && !in_ready) low_seen = 1'b1;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: got %h expected no word (cycle %0d)", out_data, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("data", out_data, mon_e.val);
          if (lat_chk) chk("latency", 32'(cyc - mon_e.acc), 32'd3);
        end
      end
      if (in_valid && in_ready) q.push_back('{val: ref_conv(in_data), acc: cyc + 1});
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    bit ok;
    int budget;
    ok = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!ok && budget < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      budget++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL push_timeout: in_ready stayed 0 for word %h, required 1", w);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q.size() != 0 || out_valid) && b < 500) begin
      step();
      b++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] w;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    for (int i = 0; i < 10; i++) chk($sformatf("model_%h", DIR_IN[i]), ref_conv(DIR_IN[i]), DIR_EXP[i]);

    // Back-to-back directed stream with the exact three-cycle latency enforced.
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) push_word(DIR_IN[i]);
    drain();
    lat_chk = 1'b0;

    // Backpressure: consumer stalls for six cycles while five words flow in.
    base = out_cnt;
    low_seen = 1'b0;
    fork
      begin
        for (int c = 0; c < 20; c++) begin
          out_ready = !(c >= 4 && c < 10);
          step();
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 5; i++) push_word(BP_IN[i]);
      end
    join
    drain();
    chk("bp_count", 32'(out_cnt - base), 32'd5);
    chk("bp_in_ready_low", 32'(low_seen), 32'd1);

    // Reset with three words in flight: nothing may emerge afterwards.
    push_word(32'd11);
    push_word(32'hFFFF_FF00);
    push_word(32'h0040_0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = out_cnt;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'h0);
    step();
    repeat (10) step();
    chk("midrst_no_stale", 32'(out_cnt - base), 32'd0);

    // Random traffic with random bubbles and consumer stalls.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      case ($urandom_range(0, 7))
        4:       w = 32'($urandom_range(0, 255));
        5:       w = 32'd0 - 32'($urandom_range(1, 255));
        6:       w = 32'h7FFF_FF80 + 32'($urandom_range(0, 255));
        7:       w = DIR_IN[$urandom_range(0, 9)];
        default: w = $urandom;
      endcase
      push_word(w);
    end
    rnd_on = 1'b0;
    step();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
